// File: rtl/pc_fetch_pkg.sv
// Shared definitions for the PC/fetch sequencer: FSM encoding and reset defaults.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pc_fetch_pkg;

    typedef enum logic [1:0] {
        BOOT   = 2'd0,
        FETCH  = 2'd1,
        HOLD   = 2'd2,
        HALTED = 2'd3
    } state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam int unsigned PC_INC_DEFAULT   = 4;

endpackage

// File: rtl/pc_fetch_sequencer_if.sv
// Bundles the instruction-memory req/ack port and the decode valid/stall port.
// Latency: n/a (wires only).
// Backpressure: imem_ack completes a held request; stall freezes the delivered instruction.
interface pc_fetch_sequencer_if #(
    parameter int ADDR_W = 32
);
    logic              imem_req;
    logic [ADDR_W-1:0] imem_addr;
    logic              imem_ack;
    logic [31:0]       imem_rdata;
    logic              instr_valid;
    logic [31:0]       instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              stall;

    // Sequencer side: drives fetch requests and the decode-facing instruction.
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ack, imem_rdata, stall
    );

    // Memory/decode side.
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ack, imem_rdata, stall
    );
endinterface

// File: rtl/pc_incrementer.sv
// Sequential-PC adder: pc + PC_INC, wrapping modulo 2^ADDR_W.
// Latency: combinational.
// Backpressure: none.
module pc_incrementer #(
    parameter int          ADDR_W = 32,
    parameter int unsigned PC_INC = 4
) (
    input  logic [ADDR_W-1:0] pc_i,
    output logic [ADDR_W-1:0] pc_next_o
);

    // Carry out of the top bit is dropped so the top word wraps to zero.
    assign pc_next_o = pc_i + ADDR_W'(PC_INC);

endmodule

// File: rtl/pc_fetch_sequencer.sv
// Owns the PC and sequences req/ack instruction fetch, delivering words to decode.
// Latency: req to instr_valid is ack latency + 1 cycle (2 cycles with 1-cycle memory).
// Backpressure: stall at the ack edge parks the word in HOLD with no new request until consumed.
module pc_fetch_sequencer
    import pc_fetch_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT),
    parameter int unsigned       PC_INC   = PC_INC_DEFAULT
) (
    input  logic                        clk,
    input  logic                        rst_n,
    pc_fetch_sequencer_if.master        bus,
    input  logic                        branch_taken,
    input  logic [ADDR_W-1:0]           branch_target,
    input  logic                        halt,
    output logic                        misalign_err
);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic              squash_q, squash_d;
    logic              valid_q, valid_d;
    logic [31:0]       instr_q, instr_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic              misalign_q, misalign_d;
    logic [ADDR_W-1:0] pc_inc;
    logic [ADDR_W-1:0] imem_addr;

    pc_incrementer #(
        .ADDR_W (ADDR_W),
        .PC_INC (PC_INC)
    ) u_inc (
        .pc_i      (pc_q),
        .pc_next_o (pc_inc)
    );

    // While a squashed request is still in flight the memory must keep seeing
    // its original address, even though pc already points at the redirect.
    assign imem_addr        = squash_q ? hold_addr_q : pc_q;
    assign bus.imem_addr    = imem_addr;
    assign bus.imem_req     = (state_q == FETCH);
    assign bus.instr_valid  = valid_q;
    assign bus.instr        = instr_q;
    assign bus.instr_pc     = instr_pc_q;
    assign misalign_err     = misalign_q;

    // Next-state: redirect beats ack/stall, which beat halt.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        squash_d    = squash_q;
        hold_addr_d = hold_addr_q;
        valid_d     = valid_q;
        instr_d     = instr_q;
        instr_pc_d  = instr_pc_q;
        misalign_d  = misalign_q;

        if (branch_taken) begin
            pc_d       = {branch_target[ADDR_W-1:2], 2'b00};
            misalign_d = misalign_q | (|branch_target[1:0]);
            valid_d    = 1'b0;
            case (state_q)
                BOOT:  state_d = FETCH;
                FETCH: begin
                    if (bus.imem_ack) begin
                        // Coincident ack: its data is dropped, nothing left in flight.
                        squash_d = 1'b0;
                    end else begin
                        squash_d    = 1'b1;
                        hold_addr_d = imem_addr;
                    end
                end
                HOLD:  state_d = halt ? HALTED : FETCH;
                default: ;  // HALTED: only pc (and the held word) are affected
            endcase
        end else begin
            case (state_q)
                BOOT:  state_d = FETCH;
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (squash_q) begin
                            squash_d = 1'b0;
                            valid_d  = 1'b0;
                            state_d  = halt ? HALTED : FETCH;
                        end else begin
                            instr_d    = bus.imem_rdata;
                            instr_pc_d = pc_q;
                            valid_d    = 1'b1;
                            pc_d       = pc_inc;
                            if (bus.stall)  state_d = HOLD;
                            else if (halt)  state_d = HALTED;
                            else            state_d = FETCH;
                        end
                    end else begin
                        valid_d = 1'b0;
                    end
                end
                HOLD: begin
                    // First non-stalled cycle consumes the parked word.
                    if (!bus.stall || !valid_q) begin
                        valid_d = 1'b0;
                        state_d = halt ? HALTED : FETCH;
                    end
                end
                default: begin  // HALTED
                    valid_d = valid_q & bus.stall;
                    if (!halt) state_d = FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= BOOT;
            pc_q        <= RESET_PC;
            hold_addr_q <= '0;
            squash_q    <= 1'b0;
            valid_q     <= 1'b0;
            instr_q     <= '0;
            instr_pc_q  <= '0;
            misalign_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            hold_addr_q <= hold_addr_d;
            squash_q    <= squash_d;
            valid_q     <= valid_d;
            instr_q     <= instr_d;
            instr_pc_q  <= instr_pc_d;
            misalign_q  <= misalign_d;
        end
    end

endmodule
